// File: rtl/custom_deser_16x4_pingpong.sv
// custom_deser_16x4_pingpong
//   Serial-in, 4-lane-parallel-out ping-pong block buffer for the 2D DCT
//   datapath. Sixteen DW-bit words (one 4x4 block) are written serially into
//   one of two 16-entry banks. A full bank is replayed as four 4-lane beats,
//   row-order (TRANSPOSE=0) or column-order (TRANSPOSE=1), while the other
//   bank fills.
//
// Ports
//   clk         in   1   clock, rising edge
//   rst         in   1   asynchronous reset, active-low
//   flush       in   1   synchronous clear of pointers/flags, active-high
//   din         in   DW  serial input word
//   din_valid   in   1   din valid
//   din_ready   out  1   write bank can accept din
//   dout0..3    out  DW  parallel output lanes
//   dout_valid  out  1   dout0..3 hold a valid beat
//   dout_ready  in   1   consumer accepts the current beat
//   beat_idx    out  2   index 0..3 of the beat on dout
//   blk_done    out  1   last beat of a block handshaken
//   bank_full   out  2   per-bank "complete, undrained block" flag
module custom_deser_16x4_pingpong #(
    parameter int unsigned DW        = 36,
    parameter bit          TRANSPOSE = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    output logic [DW-1:0] dout3,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [1:0]    beat_idx,
    output logic          blk_done,
    output logic [1:0]    bank_full
);

    logic [DW-1:0] mem_q [2][16];

    logic          wr_bank_q,    wr_bank_d;
    logic [3:0]    wr_idx_q,     wr_idx_d;
    logic          rd_bank_q,    rd_bank_d;
    logic [1:0]    rd_beat_q,    rd_beat_d;
    logic [1:0]    bank_full_q,  bank_full_d;
    logic [DW-1:0] dout_q [4];
    logic [DW-1:0] dout_d [4];
    logic          dout_valid_q, dout_valid_d;
    logic [1:0]    beat_idx_q,   beat_idx_d;

    logic          wr_en;
    logic          load;
    logic [3:0]    lane_addr;
    logic [DW-1:0] rd_word [4];

    always_comb begin
        din_ready = !bank_full_q[wr_bank_q];
        // flush suppresses both the write and the load of this cycle
        wr_en     = din_valid && din_ready && !flush;
        load      = bank_full_q[rd_bank_q] && (!dout_valid_q || dout_ready) && !flush;

        // Word address is {row, col}; transposed beats walk a column.
        lane_addr = '0;
        for (int unsigned j = 0; j < 4; j++) begin
            lane_addr  = TRANSPOSE ? {2'(j), rd_beat_q} : {rd_beat_q, 2'(j)};
            rd_word[j] = mem_q[rd_bank_q][lane_addr];
        end
    end

    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_idx_d     = wr_idx_q;
        rd_bank_d    = rd_bank_q;
        rd_beat_d    = rd_beat_q;
        bank_full_d  = bank_full_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        beat_idx_d   = beat_idx_q;

        if (flush) begin
            wr_bank_d    = 1'b0;
            wr_idx_d     = '0;
            rd_bank_d    = 1'b0;
            rd_beat_d    = '0;
            bank_full_d  = '0;
            dout_valid_d = 1'b0;
            beat_idx_d   = '0;
            for (int unsigned j = 0; j < 4; j++) begin
                dout_d[j] = '0;
            end
        end else begin
            if (wr_en) begin
                wr_idx_d = wr_idx_q + 4'd1;
                if (wr_idx_q == 4'd15) begin
                    bank_full_d[wr_bank_q] = 1'b1;
                    wr_bank_d              = !wr_bank_q;
                end
            end
            // A write only targets a non-full bank and a load only reads a
            // full one, so the set above and the clear below never collide.
            if (load) begin
                dout_d       = rd_word;
                beat_idx_d   = rd_beat_q;
                dout_valid_d = 1'b1;
                rd_beat_d    = rd_beat_q + 2'd1;
                if (rd_beat_q == 2'd3) begin
                    bank_full_d[rd_bank_q] = 1'b0;
                    rd_bank_d              = !rd_bank_q;
                end
            end else if (dout_ready) begin
                dout_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank_q    <= 1'b0;
            wr_idx_q     <= '0;
            rd_bank_q    <= 1'b0;
            rd_beat_q    <= '0;
            bank_full_q  <= '0;
            dout_valid_q <= 1'b0;
            beat_idx_q   <= '0;
            for (int unsigned j = 0; j < 4; j++) begin
                dout_q[j] <= '0;
            end
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            rd_bank_q    <= rd_bank_d;
            rd_beat_q    <= rd_beat_d;
            bank_full_q  <= bank_full_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            beat_idx_q   <= beat_idx_d;
        end
    end

    // Block storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_idx_q] <= din;
        end
    end

    assign dout0      = dout_q[0];
    assign dout1      = dout_q[1];
    assign dout2      = dout_q[2];
    assign dout3      = dout_q[3];
    assign dout_valid = dout_valid_q;
    assign beat_idx   = beat_idx_q;
    assign bank_full  = bank_full_q;
    assign blk_done   = dout_valid_q && dout_ready && (beat_idx_q == 2'd3);

endmodule

// File: tb/tb_custom_deser_16x4_pingpong.sv
// Bench for custom_deser_16x4_pingpong: one column-order and one row-order
// instance share all inputs; a block-level model predicts the beats of every
// completed 16-word block and a negedge monitor compares each handshaken beat.
module tb_custom_deser_16x4_pingpong;

    localparam int unsigned DW = 36;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [DW-1:0] din;
    logic          din_valid;
    logic          dout_ready = 1'b0;

    logic          rdy_t, rdy_r;
    logic [DW-1:0] lt [4];
    logic [DW-1:0] lr [4];
    logic          vt, vr;
    logic [1:0]    it, ir;
    logic          dt, dr;
    logic [1:0]    ft, fr;

    always #5 clk = ~clk;

    custom_deser_16x4_pingpong #(.DW(DW), .TRANSPOSE(1'b1)) dut_t (
        .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
        .din_ready(rdy_t), .dout0(lt[0]), .dout1(lt[1]), .dout2(lt[2]), .dout3(lt[3]),
        .dout_valid(vt), .dout_ready(dout_ready), .beat_idx(it), .blk_done(dt),
        .bank_full(ft)
    );

    custom_deser_16x4_pingpong #(.DW(DW), .TRANSPOSE(1'b0)) dut_r (
        .clk(clk), .rst(rst), .flush(flush), .din(din), .din_valid(din_valid),
        .din_ready(rdy_r), .dout0(lr[0]), .dout1(lr[1]), .dout2(lr[2]), .dout3(lr[3]),
        .dout_valid(vr), .dout_ready(dout_ready), .beat_idx(ir), .blk_done(dr),
        .bank_full(fr)
    );

    typedef struct {
        logic [DW-1:0] t [4];
        logic [DW-1:0] r [4];
        logic [1:0]    idx;
    } beat_t;

    beat_t         expq [$];
    logic [DW-1:0] part [$];
    int            errors = 0;
    int            checks = 0;
    int            done_t = 0;
    int            done_r = 0;
    int            rdy_mode = 1;   // 0: hold off, 1: always ready, 2: random

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Block model: word w of a block sits at row w/4, column w%4.
    task automatic model_accept(input logic [DW-1:0] w);
        beat_t b;
        part.push_back(w);
        if (part.size() == 16) begin
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    b.t[j] = part[4*j + k];
                    b.r[j] = part[4*k + j];
                end
                b.idx = 2'(k);
                expq.push_back(b);
            end
            part.delete();
        end
    endtask

    task automatic model_clear();
        part.delete();
        expq.delete();
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dout_ready = 1'b0;
            1:       dout_ready = 1'b1;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor
    logic          hold_q = 1'b0;
    logic          prev_flush = 1'b0;
    logic [DW-1:0] s_lt [4];
    logic [DW-1:0] s_lr [4];
    logic [1:0]    s_it, s_ir;

    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            hold_q <= 1'b0;
        end else begin
            if (hold_q && !prev_flush) begin
                chk("hold_valid_t", vt, 1);
                chk("hold_valid_r", vr, 1);
                chk("hold_idx_t", it, s_it);
                chk("hold_idx_r", ir, s_ir);
                for (int j = 0; j < 4; j++) begin
                    chk($sformatf("hold_t_lane%0d", j), lt[j], s_lt[j]);
                    chk($sformatf("hold_r_lane%0d", j), lr[j], s_lr[j]);
                end
            end
            if (dout_ready && (vt || vr)) begin
                if (expq.size() == 0) begin
                    chk("unexpected_beat", {vt, vr}, 0);
                end else begin
                    e = expq.pop_front();
                    chk("beat_valid_t", vt, 1);
                    chk("beat_valid_r", vr, 1);
                    chk("beat_idx_t", it, e.idx);
                    chk("beat_idx_r", ir, e.idx);
                    chk("blk_done_t", dt, (e.idx == 2'd3));
                    chk("blk_done_r", dr, (e.idx == 2'd3));
                    for (int j = 0; j < 4; j++) begin
                        chk($sformatf("col_lane%0d", j), lt[j], e.t[j]);
                        chk($sformatf("row_lane%0d", j), lr[j], e.r[j]);
                    end
                end
            end else begin
                chk("blk_done_idle_t", dt, 0);
                chk("blk_done_idle_r", dr, 0);
            end
            if (dt) done_t <= done_t + 1;
            if (dr) done_r <= done_r + 1;
            hold_q <= (vt || vr) && !dout_ready;
            s_lt   <= lt;
            s_lr   <= lr;
            s_it   <= it;
            s_ir   <= ir;
        end
        prev_flush <= flush;
    end

    task automatic send_word(input logic [DW-1:0] w, output int waits);
        waits = 0;
        @(posedge clk);
        #1;
        din       = w;
        din_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (rdy_t) begin
                model_accept(w);
                break;
            end
            waits++;
            if (waits > 300) begin
                chk("send_timeout", 64'(waits), 0);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_valid = 1'b0;
            din       = '0;
        end
    endtask

    task automatic drain();
        int c = 0;
        while (expq.size() != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("drain_empty", 64'(expq.size()), 0);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid_t"}, vt, 0);
        chk({tag, "_valid_r"}, vr, 0);
        chk({tag, "_full_t"}, ft, 0);
        chk({tag, "_full_r"}, fr, 0);
        chk({tag, "_ready_t"}, rdy_t, 1);
        chk({tag, "_ready_r"}, rdy_r, 1);
        chk({tag, "_idx_t"}, it, 0);
        chk({tag, "_done_t"}, dt, 0);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("%s_lane_t%0d", tag, j), lt[j], 0);
            chk($sformatf("%s_lane_r%0d", tag, j), lr[j], 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, maxw, n, d0;
        rst       = 1'b0;
        flush     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        #12;
        check_cleared("reset");
        @(posedge clk);
        #2;
        rst = 1'b1;

        // Both orderings of 0..15, streaming beats
        rdy_mode = 1;
        idle(2);
        for (int i = 0; i < 16; i++) send_word(DW'(i), w);
        idle(1);
        n = 0;
        while (!vt && n < 4) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 4; k++) begin
            chk("consec_valid", vt, 1);
            chk("consec_idx", it, k);
            @(negedge clk);
        end
        drain();

        // 32 words continuous: never back-pressured, two blocks done
        d0   = done_t;
        maxw = 0;
        for (int i = 0; i < 32; i++) begin
            send_word(DW'(i), w);
            if (w > maxw) maxw = w;
        end
        idle(1);
        drain();
        idle(2);
        chk("stream_waits", 64'(maxw), 0);
        chk("stream_blk_done", 64'(done_t - d0), 2);

        // Consumer stalled: exactly two blocks absorbed
        rdy_mode = 0;
        idle(2);
        n = 0;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk);
            #1;
            din       = DW'(n);
            din_valid = (n <= 40);
            @(negedge clk);
            if (rdy_t && din_valid) begin
                model_accept(DW'(n));
                n++;
            end
        end
        chk("stall_accepted", 64'(n), 32);
        chk("stall_full_t", ft, 2'b11);
        chk("stall_full_r", fr, 2'b11);
        chk("stall_ready_t", rdy_t, 0);
        chk("stall_beat_valid", vt, 1);
        chk("stall_beat_idx", it, 0);
        rdy_mode = 1;
        w = 0;
        forever begin
            @(posedge clk);
            #1;
            din       = DW'(32);
            din_valid = 1'b1;
            @(negedge clk);
            if (rdy_t) begin
                model_accept(DW'(32));
                break;
            end
            w++;
            if (w > 20) break;
        end
        chk("release_wait", 64'(w), 3);

        // Reset mid-block with a held beat and a partial block
        rdy_mode = 0;
        for (int i = 33; i < 39; i++) send_word(DW'(i), w);
        idle(2);
        chk("pre_reset_valid", vt, 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async_rst");
        model_clear();
        rdy_mode = 1;
        idle(2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        for (int i = 100; i < 116; i++) send_word(DW'(i), w);
        idle(1);
        drain();

        // Random words, gaps and back-pressure
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send_word(DW'({$urandom(), $urandom()}), w);
        end
        idle(1);
        rdy_mode = 1;
        drain();

        // flush with a waiting beat and an offered word
        rdy_mode = 0;
        idle(2);
        for (int i = 200; i < 216; i++) send_word(DW'(i), w);
        idle(3);
        chk("pre_flush_valid", vt, 1);
        @(posedge clk);
        #1;
        flush     = 1'b1;
        din_valid = 1'b1;
        din       = DW'(999);
        @(negedge clk);
        model_clear();
        @(posedge clk);
        #1;
        flush     = 1'b0;
        din_valid = 1'b0;
        @(negedge clk);
        check_cleared("flush");
        rdy_mode = 1;
        for (int i = 300; i < 316; i++) send_word(DW'(i), w);
        idle(1);
        drain();
        idle(4);
        chk("final_queue", 64'(expq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
